// File: rtl/nrx_irq_latch.sv
// nrx_irq_latch -- Namco Z80 addressable output latch, IM2 vector register and prioritised interrupt latch.
// Rev 1.0
`default_nettype none

module nrx_irq_latch #(
  parameter int NSRC    = 2,
  parameter int LAW     = 3,
  parameter int IEBASE  = 1,
  parameter int EDGE    = 1,
  parameter int VMODE   = 0,
  parameter int AUTOCLR = 1
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic                CE,
  input  logic                LAT_WE,
  input  logic [LAW-1:0]      LAT_AD,
  input  logic                VEC_WE,
  input  logic [7:0]          DI,
  input  logic                IACK,
  input  logic [NSRC-1:0]     SRC,
  output logic                IRQ_n,
  output logic [7:0]          VEC,
  output logic [2**LAW-1:0]   LAT,
  output logic [NSRC-1:0]     PEND
);

  localparam int NLAT = 2**LAW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [NLAT-1:0]   r_lat;
  logic [7:0]        r_vreg;
  logic [NSRC-1:0]   r_prev;
  logic [NSRC-1:0]   r_pend;
  logic              r_irq_n;
  logic [2:0]        r_svc;

  logic [NSRC-1:0]   w_en;
  logic [NSRC-1:0]   w_req;
  logic              w_any;
  logic [2:0]        w_sel;
  logic [NSRC-1:0]   w_set;
  logic [NSRC-1:0]   w_enclr;
  logic [NSRC-1:0]   w_ackclr;
  logic [NSRC-1:0]   w_pend_nxt;
  logic              w_take;
  logic [2:0]        w_idx;

  assign w_en   = r_lat[IEBASE +: NSRC];
  assign w_req  = r_pend & w_en;
  assign w_any  = |w_req;
  assign w_set  = (EDGE != 0) ? (SRC & ~r_prev) : SRC;
  assign w_take = CE && (r_state == S_IDLE) && IACK;

  // Lowest index wins; falls back to 0 when nothing is requesting.
  always_comb begin
    w_sel = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel = 3'(i);
    end
  end

  always_comb begin
    w_enclr  = '0;
    w_ackclr = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_enclr[i]  = LAT_WE && (LAT_AD == LAW'(IEBASE + i));
      w_ackclr[i] = (AUTOCLR != 0) && w_take && w_any && (w_sel == 3'(i));
    end
  end

  // New detects beat the acknowledge clear; enable writes beat everything.
  assign w_pend_nxt = ((r_pend & ~w_ackclr) | w_set) & ~w_enclr;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (CE && IACK)  w_state_nxt = S_ACK;
      S_ACK:   if (CE && !IACK) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_lat   <= '0;
      r_vreg  <= 8'h00;
      r_prev  <= '1;
      r_pend  <= '0;
      r_irq_n <= 1'b1;
      r_svc   <= 3'd0;
    end else if (CE) begin
      if (LAT_WE) r_lat[LAT_AD] <= DI[0];
      if (VEC_WE) r_vreg <= DI;
      r_prev  <= SRC;
      r_pend  <= w_pend_nxt;
      r_irq_n <= ~w_any;
      if (w_take) r_svc <= w_sel;
    end
  end

  assign w_idx = (r_state == S_ACK) ? r_svc : w_sel;
  assign VEC   = (VMODE != 0) ? {r_vreg[7:3], w_idx} : r_vreg;
  assign IRQ_n = r_irq_n;
  assign LAT   = r_lat;
  assign PEND  = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_nrx_irq_latch.sv
// tb_nrx_irq_latch -- directed vector table plus hand sequences for nrx_irq_latch.
// Rev 1.0
`default_nettype none

module tb_nrx_irq_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce;
  logic       lat_we;
  logic [2:0] lat_ad;
  logic       vec_we;
  logic [7:0] di;
  logic       iack;
  logic [1:0] src;

  logic       d_irq_n, m_irq_n, l_irq_n;
  logic [7:0] d_vec, m_vec, l_vec;
  logic [7:0] d_lat, m_lat, l_lat;
  logic [1:0] d_pend, m_pend, l_pend;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nrx_irq_latch #(.NSRC(2), .LAW(3), .IEBASE(1), .EDGE(1), .VMODE(0), .AUTOCLR(1)) u_dut (
    .CLK(clk), .RESET_n(rst_n), .CE(ce), .LAT_WE(lat_we), .LAT_AD(lat_ad),
    .VEC_WE(vec_we), .DI(di), .IACK(iack), .SRC(src),
    .IRQ_n(d_irq_n), .VEC(d_vec), .LAT(d_lat), .PEND(d_pend)
  );

  nrx_irq_latch #(.NSRC(2), .LAW(3), .IEBASE(1), .EDGE(1), .VMODE(1), .AUTOCLR(1)) u_vm (
    .CLK(clk), .RESET_n(rst_n), .CE(ce), .LAT_WE(lat_we), .LAT_AD(lat_ad),
    .VEC_WE(vec_we), .DI(di), .IACK(iack), .SRC(src),
    .IRQ_n(m_irq_n), .VEC(m_vec), .LAT(m_lat), .PEND(m_pend)
  );

  nrx_irq_latch #(.NSRC(2), .LAW(3), .IEBASE(1), .EDGE(0), .VMODE(0), .AUTOCLR(1)) u_lv (
    .CLK(clk), .RESET_n(rst_n), .CE(ce), .LAT_WE(lat_we), .LAT_AD(lat_ad),
    .VEC_WE(vec_we), .DI(di), .IACK(iack), .SRC(src),
    .IRQ_n(l_irq_n), .VEC(l_vec), .LAT(l_lat), .PEND(l_pend)
  );

  typedef struct {
    string      nm;
    logic       ce;
    logic       lwe;
    logic [2:0] lad;
    logic       vwe;
    logic [7:0] di;
    logic       iack;
    logic [1:0] src;
    logic       irq_n;
    logic [1:0] pend;
    logic [7:0] lat;
    logic [7:0] vec;
  } row_t;

  row_t tbl[$];

  task automatic add(input string nm, input logic c, input logic lw, input logic [2:0] la,
                     input logic vw, input logic [7:0] d, input logic ia, input logic [1:0] s,
                     input logic e_irq, input logic [1:0] e_pend, input logic [7:0] e_lat,
                     input logic [7:0] e_vec);
    row_t r;
    r.nm = nm; r.ce = c; r.lwe = lw; r.lad = la; r.vwe = vw; r.di = d; r.iack = ia; r.src = s;
    r.irq_n = e_irq; r.pend = e_pend; r.lat = e_lat; r.vec = e_vec;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the edge.
  task automatic drv(input logic c, input logic lw, input logic [2:0] la, input logic vw,
                     input logic [7:0] d, input logic ia, input logic [1:0] s);
    ce = c; lat_we = lw; lat_ad = la; vec_we = vw; di = d; iack = ia; src = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ce lwe lad vwe di iack src | irq_n pend lat vec
    add("src_low",    1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h00,8'h00);
    add("src0_rise",  1,0,3'd0,0,8'h00,0,2'b01, 1,2'b01,8'h00,8'h00);
    add("vec_wr",     1,0,3'd0,1,8'hCF,0,2'b00, 1,2'b01,8'h00,8'hCF);
    add("en0_clr",    1,1,3'd1,0,8'h01,0,2'b00, 1,2'b00,8'h02,8'hCF);
    add("pulse1",     1,0,3'd0,0,8'h00,0,2'b01, 1,2'b01,8'h02,8'hCF);
    add("irq_low1",   1,0,3'd0,0,8'h00,0,2'b00, 0,2'b01,8'h02,8'hCF);
    add("ce_hold",    0,1,3'd1,1,8'h00,0,2'b00, 0,2'b01,8'h02,8'hCF);
    add("iack_rise",  1,0,3'd0,0,8'h00,1,2'b00, 0,2'b00,8'h02,8'hCF);
    add("iack_hold",  1,0,3'd0,0,8'h00,1,2'b00, 1,2'b00,8'h02,8'hCF);
    add("iack_drop",  1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h02,8'hCF);
    add("pulse2",     1,0,3'd0,0,8'h00,0,2'b01, 1,2'b01,8'h02,8'hCF);
    add("irq_low2",   1,0,3'd0,0,8'h00,0,2'b00, 0,2'b01,8'h02,8'hCF);
    add("en_wr",      1,1,3'd1,0,8'h01,0,2'b00, 0,2'b00,8'h02,8'hCF);
    add("irq_high",   1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h02,8'hCF);
    add("coll_en",    1,1,3'd1,0,8'h01,0,2'b01, 1,2'b00,8'h02,8'hCF);
    add("low3",       1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h02,8'hCF);
    add("rise4",      1,0,3'd0,0,8'h00,0,2'b01, 1,2'b01,8'h02,8'hCF);
    add("low4",       1,0,3'd0,0,8'h00,0,2'b00, 0,2'b01,8'h02,8'hCF);
    add("coll_ack",   1,0,3'd0,0,8'h00,1,2'b01, 0,2'b01,8'h02,8'hCF);
    add("ack_hold",   1,0,3'd0,0,8'h00,1,2'b01, 0,2'b01,8'h02,8'hCF);
    add("ack_end",    1,0,3'd0,0,8'h00,0,2'b00, 0,2'b01,8'h02,8'hCF);
    add("en_off",     1,1,3'd1,0,8'h00,0,2'b00, 0,2'b00,8'h00,8'hCF);
    add("idle",       1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h00,8'hCF);
    add("vec_iack",   1,0,3'd0,1,8'hA5,1,2'b00, 1,2'b00,8'h00,8'hA5);
    add("iack_off",   1,0,3'd0,0,8'h00,0,2'b00, 1,2'b00,8'h00,8'hA5);

    // Reset with both sources already high.
    rst_n = 1'b0;
    drv(1,0,3'd0,0,8'h00,0,2'b11);
    drv(1,0,3'd0,0,8'h00,0,2'b11);
    chk("rst.pend", 32'(d_pend), 32'h0);
    chk("rst.irq",  32'(d_irq_n), 32'h1);
    chk("rst.lat",  32'(d_lat), 32'h0);
    chk("rst.vec",  32'(d_vec), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drv(1,0,3'd0,0,8'h00,0,2'b11);
      chk($sformatf("post_rst%0d.pend", i), 32'(d_pend), 32'h0);
      chk($sformatf("post_rst%0d.irq", i),  32'(d_irq_n), 32'h1);
      chk($sformatf("post_rst%0d.lat", i),  32'(d_lat), 32'h0);
    end

    foreach (tbl[k]) begin
      drv(tbl[k].ce, tbl[k].lwe, tbl[k].lad, tbl[k].vwe, tbl[k].di, tbl[k].iack, tbl[k].src);
      chk($sformatf("%s.irq",  tbl[k].nm), 32'(d_irq_n), 32'(tbl[k].irq_n));
      chk($sformatf("%s.pend", tbl[k].nm), 32'(d_pend),  32'(tbl[k].pend));
      chk($sformatf("%s.lat",  tbl[k].nm), 32'(d_lat),   32'(tbl[k].lat));
      chk($sformatf("%s.vec",  tbl[k].nm), 32'(d_vec),   32'(tbl[k].vec));
    end

    // Priority with per-source vectors: source 1 first, source 0 one CE later.
    drv(1,0,3'd0,1,8'hF8,0,2'b00);
    drv(1,1,3'd1,0,8'h01,0,2'b00);
    drv(1,1,3'd2,0,8'h01,0,2'b00);
    chk("prio.lat", 32'(m_lat), 32'h06);
    drv(1,0,3'd0,0,8'h00,0,2'b10);
    chk("prio.pend1", 32'(m_pend), 32'h2);
    drv(1,0,3'd0,0,8'h00,0,2'b11);
    chk("prio.pend2", 32'(m_pend), 32'h3);
    chk("prio.irq",   32'(m_irq_n), 32'h0);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("prio.sel_vec", 32'(m_vec), 32'hF8);
    drv(1,0,3'd0,0,8'h00,1,2'b00);
    chk("prio.ack0_vec", 32'(m_vec), 32'hF8);
    chk("prio.ack0_raw", 32'(d_vec), 32'hF8);
    chk("prio.ack0_pend", 32'(m_pend), 32'h2);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("prio.idle_vec", 32'(m_vec), 32'hF9);
    drv(1,0,3'd0,0,8'h00,1,2'b00);
    chk("prio.ack1_vec", 32'(m_vec), 32'hF9);
    chk("prio.ack1_pend", 32'(m_pend), 32'h0);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("prio.irq_done", 32'(m_irq_n), 32'h1);
    chk("prio.end_vec",  32'(m_vec), 32'hF8);

    // Level mode: a held source re-asserts straight through the acknowledge.
    drv(1,1,3'd1,0,8'h01,0,2'b00);
    drv(1,1,3'd2,0,8'h00,0,2'b00);
    chk("lvl.clr_pend", 32'(l_pend), 32'h0);
    drv(1,0,3'd0,0,8'h00,0,2'b01);
    drv(1,0,3'd0,0,8'h00,0,2'b01);
    chk("lvl.irq_low", 32'(l_irq_n), 32'h0);
    drv(1,0,3'd0,0,8'h00,1,2'b01);
    chk("lvl.ack_pend",  32'(l_pend), 32'h1);
    chk("lvl.edge_pend", 32'(d_pend), 32'h0);
    drv(1,0,3'd0,0,8'h00,0,2'b01);
    chk("lvl.post_pend", 32'(l_pend), 32'h1);
    chk("lvl.post_irq",  32'(l_irq_n), 32'h0);
    chk("lvl.edge_irq",  32'(d_irq_n), 32'h1);
    drv(1,1,3'd1,0,8'h01,0,2'b00);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("lvl.end_pend", 32'(l_pend), 32'h0);
    chk("lvl.end_irq",  32'(l_irq_n), 32'h1);

    // Latch pattern, then reset in the middle of an acknowledge.
    for (int i = 0; i < 8; i++)
      drv(1,1,3'(i),0,(i % 2 == 0) ? 8'hFF : 8'hFE,0,2'b00);
    chk("latch.pattern", 32'(d_lat), 32'h55);
    drv(1,0,3'd0,0,8'h00,0,2'b10);
    chk("mid.pend", 32'(d_pend), 32'h2);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("mid.irq", 32'(d_irq_n), 32'h0);
    drv(1,0,3'd0,0,8'h00,1,2'b00);
    rst_n = 1'b0;
    drv(0,0,3'd0,0,8'h00,1,2'b11);
    chk("mid_rst.lat",  32'(d_lat), 32'h0);
    chk("mid_rst.irq",  32'(d_irq_n), 32'h1);
    chk("mid_rst.pend", 32'(d_pend), 32'h0);
    chk("mid_rst.vec",  32'(m_vec), 32'h0);
    rst_n = 1'b1;
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    drv(1,1,3'd1,0,8'h01,0,2'b00);
    drv(1,0,3'd0,0,8'h00,0,2'b01);
    chk("after_rst.pend", 32'(d_pend), 32'h1);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("after_rst.irq", 32'(d_irq_n), 32'h0);
    drv(1,0,3'd0,0,8'h00,1,2'b00);
    chk("after_rst.ack_pend", 32'(d_pend), 32'h0);
    drv(1,0,3'd0,0,8'h00,0,2'b00);
    chk("after_rst.irq_high", 32'(d_irq_n), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nrx_irq_latch.md
# nrx_irq_latch

Parametrised interrupt/latch controller for the Namco Z80 boards: the board's addressable output latch, the IM2 vector register and a generalised interrupt latch, in one block. The video and sound blocks drive a set of interrupt sources (VBLANK and others); the CPU address decoder drives the write strobes. The block has N prioritised sources, per-source enables taken from latch bits, optional per-source vector generation, and an acknowledge handshake that holds the vector stable.

## Interface
Parameters:
- NSRC, 2, number of interrupt sources (1-8); index 0 is highest priority
- LAW, 3, latch address width; latch has 2^LAW single-bit outputs
- IEBASE, 1, latch bit index of source 0's enable; source i uses bit IEBASE+i (IEBASE+NSRC ≤ 2^LAW)
- EDGE, 1, 1 = rising-edge-triggered sources, 0 = level-triggered
- VMODE, 0, 0 = VEC is the raw vector register; 1 = VEC = {register[7:3], source index[2:0]}
- AUTOCLR, 1, 1 = acknowledge clears the serviced source's pending flag

Ports:
- CLK  in  1  system clock (24.576 MHz)
- RESET_n  in  1  synchronous active-low reset
- CE  in  1  CPU clock-enable strobe; all state updates only on CLK edges with CE=1
- LAT_WE  in  1  decoded write to latch region
- LAT_AD  in  LAW  latch bit address
- VEC_WE  in  1  I/O write to vector register
- DI  in  8  CPU data out
- IACK  in  1  interrupt-acknowledge cycle (M1 and IORQ both active), active-high
- SRC  in  NSRC  interrupt requests, active-high
- IRQ_n  out  1  to CPU INT_n
- VEC  out  8  vector for the data-bus mux during IACK
- LAT  out  2^LAW  latch outputs (flip, lamps, sound enable, …)
- PEND  out  NSRC  pending flags (debug/status)

## Operation
- Latch: on LAT_WE, LAT[LAT_AD] <= DI[0]. Other bits hold.
- Vector register: on VEC_WE, vreg <= DI.
- Source detect, per source i:
  - EDGE=1: set is SRC[i] & ~prev[i], where prev is SRC sampled on each CE.
  - EDGE=0: set is SRC[i].
- Pending flag pend[i]:
  - Set by its detect.
  - Cleared by a latch write to bit IEBASE+i, with either data value. Clear wins over a same-cycle set.
  - Cleared by acknowledge of source i when AUTOCLR=1. Set wins over this clear, so a new edge is never lost.
  - A disabled source still latches pending; enabling it later raises IRQ_n only if no enable write cleared it.
- Request: req = pend & LAT[IEBASE +: NSRC]. IRQ_n is registered: IRQ_n <= ~|req.
- Selection: sel = lowest index with req set. It is recomputed every CE while not in service.
- Acknowledge FSM, two states:
  - IDLE -> ACK on the first CE with IACK=1. In that cycle: capture svc <= sel, and apply the AUTOCLR clear to pend[sel].
  - ACK -> IDLE on the first CE with IACK=0.
  - In ACK, svc and VEC are frozen. Requests arriving during ACK only set pending.
  - If IACK rises with req=0, svc is captured as 0, VEC is valid, and no clear is applied.
- VEC output: VMODE=0 gives vreg. VMODE=1 gives {vreg[7:3], svc padded to 3 bits} in ACK, and {vreg[7:3], sel} in IDLE.
- Simultaneous VEC_WE and IACK: the register updates, and VEC reflects the new vreg on the next cycle.

## Timing
- Reset (RESET_n=0 on a CLK edge, regardless of CE) forces all of the following, and aborts any ACK in progress to IDLE:
  - LAT=0, vreg=0, VEC=0, PEND=0, IRQ_n=1
  - prev=all ones, so a source already high does not fire after reset
  - state=IDLE, svc=0
- Latency in CE cycles:
  - SRC rising to PEND set: 1
  - SRC rising to IRQ_n low: 2 (with the enable already set)
  - Enable write to IRQ_n high: 2
  - IACK rising to pend cleared: 1
- IRQ_n high follows one CE later provided no other req remains.
- Outputs are registered, except VEC, which is combinational from vreg/svc/sel.
- With CE held low, all state holds, including edge history.

## Test plan
- Reset: NSRC=2, EDGE=1, SRC=2'b11 held through reset release → PEND=0, IRQ_n=1, LAT=0 for 10 CE; first real rising edge on SRC[0] after a low phase → PEND=2'b01.
- Reference config (VMODE=0): VEC_WE DI=8'hCF; latch write addr 1, DI=1; SRC[0] pulse → IRQ_n low 2 CE later; IACK → VEC=8'hCF; write addr 1 → IRQ_n high 2 CE later.
- Priority: VMODE=1, vreg=8'hF8, both enabled, SRC[1] rises one CE before SRC[0], then IACK → VEC=8'hF8 (source 0); after IACK falls, second IACK → VEC=8'hF9; then IRQ_n=1.
- Collisions: edge on SRC[0] in the same CE as an enable write to bit IEBASE → PEND[0]=0. Edge in the same CE as acknowledge of source 0 → PEND[0]=1.
- Level mode: EDGE=0, SRC[0] held high, enabled, AUTOCLR=1 → after IACK, PEND[0] re-sets the next CE and IRQ_n stays low.
- Latch: write bits 0..7 alternately 1/0 with DI=8'hFF/8'hFE → LAT=8'h55; RESET_n low for one CLK mid-ACK → LAT=0, state IDLE, IRQ_n=1.
